// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared widths and types for the 16x16 register file and its write-back controller.
package regfile_writeback_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Write-request FIFO for the write-back controller; exposes every slot's address and
// occupancy so the owner can detect read-after-write hazards against queued writes.
module wb_fifo
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  wr_req_t                       i_push_req,
    input  logic                          i_pop,
    output wr_req_t                       o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [PW:0]                   o_count,
    output logic [DEPTH-1:0]              o_entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  o_entry_addr
);

    wr_req_t       r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign o_full   = (r_count == (PW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
            r_count <= r_count + (PW+1)'(w_doPush) - (PW+1)'(w_doPop);
        end
    end

    // Storage needs no reset: a slot is only observed once its occupancy bit is set.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_push_req;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_valid[i] = ({1'b0, PW'(i) - r_rdPtr} < r_count);
            o_entry_addr[i]  = r_mem[i].addr;
        end
    end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-side initiator: round-robin arbitration of two producers into a FIFO,
// one regfile write per cycle, a zeroing init sweep, and RAW hazard reporting.
module regfile_writeback_ctrl
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              init_start,
    output logic              init_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [PW:0]       pending
);

    wb_state_e                    r_state;
    wb_state_e                    w_nextState;
    logic                         r_preferB;
    logic [ADDR_W-1:0]            r_sweepCtr;
    logic                         w_grantA;
    logic                         w_grantB;
    logic                         w_canAccept;
    logic                         w_push;
    logic                         w_pop;
    wr_req_t                      w_pushReq;
    wr_req_t                      w_head;
    logic                         w_fifoFull;
    logic                         w_fifoEmpty;
    logic [DEPTH-1:0]             w_entryValid;
    logic [DEPTH-1:0][ADDR_W-1:0] w_entryAddr;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_req    (w_pushReq),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_full        (w_fifoFull),
        .o_empty       (w_fifoEmpty),
        .o_count       (pending),
        .o_entry_valid (w_entryValid),
        .o_entry_addr  (w_entryAddr)
    );

    // Ready never looks at the pop of the same cycle, so a full FIFO always stalls producers.
    always_comb begin
        w_grantA    = a_valid && (!b_valid || !r_preferB);
        w_grantB    = b_valid && !w_grantA;
        w_canAccept = (r_state == ST_RUN) && !w_fifoFull && !reset;
        a_ready     = w_canAccept && w_grantA;
        b_ready     = w_canAccept && w_grantB;
        w_push      = (a_valid && a_ready) || (b_valid && b_ready);
        w_pushReq   = a_ready ? wr_req_t'{addr: a_addr, data: a_data}
                              : wr_req_t'{addr: b_addr, data: b_data};
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN:   if (init_start) w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_fifoEmpty) w_nextState = ST_SWEEP;
            ST_SWEEP: if (r_sweepCtr == ADDR_W'(NUM_REGS - 1)) w_nextState = ST_RUN;
            default:  w_nextState = ST_RUN;
        endcase
    end

    // The head stays a hazard until the edge that commits it, so it is included in q_hit.
    always_comb begin
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        w_pop     = 1'b0;
        q_hit     = 1'b0;
        init_busy = (r_state != ST_RUN);
        if (r_state == ST_SWEEP) begin
            wr_en   = 1'b1;
            wr_addr = r_sweepCtr;
            q_hit   = 1'b1;
        end else begin
            w_pop = !w_fifoEmpty;
            wr_en = w_pop;
            if (w_pop) begin
                wr_addr = w_head.addr;
                wr_data = w_head.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_entryValid[i] && (w_entryAddr[i] == q_addr)) q_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_preferB  <= 1'b0;
            r_sweepCtr <= '0;
        end else begin
            r_state <= w_nextState;
            if (a_valid && a_ready) begin
                r_preferB <= 1'b1;
            end else if (b_valid && b_ready) begin
                r_preferB <= 1'b0;
            end
            if (r_state == ST_SWEEP) begin
                r_sweepCtr <= r_sweepCtr + 1'b1;
            end else begin
                r_sweepCtr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench for regfile_writeback_ctrl: directed scenarios plus a randomized run,
// all compared against a queue-based transaction model and a mirrored register file.
module tb_regfile_writeback_ctrl;
    import regfile_writeback_ctrl_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PW      = $clog2(DEPTH);
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_SWEEP = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid, a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr, wr_addr, q_addr;
    logic [DATA_W-1:0] a_data, b_data, wr_data;
    logic              init_start, init_busy, wr_en, q_hit;
    logic [PW:0]       pending;

    int checks = 0;
    int errors = 0;

    req_t              mq[$];
    bit                lastWasA;
    int                mMode;
    int                mSweep;
    logic [DATA_W-1:0] expRf [NUM_REGS];
    logic [DATA_W-1:0] dutRf [NUM_REGS];

    regfile_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .init_start (init_start),
        .init_busy  (init_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted writes plus "who was granted last".
    function automatic logic expReadyA();
        return !reset && mMode == M_RUN && mq.size() < DEPTH && a_valid && (!b_valid || !lastWasA);
    endfunction

    function automatic logic expReadyB();
        return !reset && mMode == M_RUN && mq.size() < DEPTH && b_valid && (!a_valid || lastWasA);
    endfunction

    function automatic logic [20:0] expWrPort();
        if (mMode == M_SWEEP) return {1'b1, 4'(mSweep), 16'h0000};
        if (mq.size() > 0) return {1'b1, mq[0].addr, mq[0].data};
        return 21'h0;
    endfunction

    function automatic logic expQHit();
        if (mMode == M_SWEEP) return 1'b1;
        foreach (mq[i]) if (mq[i].addr == q_addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mq.delete();
        lastWasA = 1'b0;
        mMode    = M_RUN;
        mSweep   = 0;
    endtask

    task automatic modelStep();
        bit   accA, accB;
        int   sz, md;
        req_t r;
        accA = expReadyA();
        accB = expReadyB();
        sz   = mq.size();
        md   = mMode;
        if (md == M_SWEEP) begin
            expRf[mSweep] = '0;
            if (mSweep == NUM_REGS - 1) begin
                mMode  = M_RUN;
                mSweep = 0;
            end else begin
                mSweep++;
            end
        end else if (sz > 0) begin
            expRf[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
        end
        if (md == M_DRAIN && sz == 0) mMode = M_SWEEP;
        if (md == M_RUN && init_start) mMode = M_DRAIN;
        if (accA) begin
            r.addr = a_addr; r.data = a_data;
            mq.push_back(r);
            lastWasA = 1'b1;
        end else if (accB) begin
            r.addr = b_addr; r.data = b_data;
            mq.push_back(r);
            lastWasA = 1'b0;
        end
    endtask

    // Called at a negedge: mirror the DUT's write, cross the edge, advance the model.
    task automatic tick();
        if (wr_en === 1'b1) dutRf[wr_addr] = wr_data;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0; b_valid = 1'b0; init_start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1; init_start = 1'b0;
        a_addr = 4'd1; b_addr = 4'd2; a_data = 16'h1111; b_data = 16'h2222; q_addr = 4'd1;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready, wr_en, wr_addr, wr_data, pending, init_busy, q_hit} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b%b we=%b wa=%h wd=%h pend=%0d busy=%b hit=%b, required all zero",
                     a_ready, b_ready, wr_en, wr_addr, wr_data, pending, init_busy, q_hit);
        end
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_rr_favours_A: got %b%b required 10", a_ready, b_ready);
        end
        tick();
        idle(2);
    endtask

    task automatic test_single_write();
        a_valid = 1'b1; b_valid = 1'b0; a_addr = 4'd3; a_data = 16'hBEEF; q_addr = 4'd3;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || pending !== 0) begin
            errors++;
            $display("[TB] FAIL single_accept: got ready=%b pend=%0d required ready=1 pend=0", a_ready, pending);
        end
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, pending} !== {1'b1, 4'd3, 16'hBEEF, 3'd1}) begin
            errors++;
            $display("[TB] FAIL single_write: got we=%b wa=%h wd=%h pend=%0d required 1 3 beef 1",
                     wr_en, wr_addr, wr_data, pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || pending !== 0) begin
            errors++;
            $display("[TB] FAIL single_done: got we=%b pend=%0d required 0 0", wr_en, pending);
        end
        tick();
    endtask

    task automatic test_alternate();
        int prev = -1;
        int cur;
        a_addr = 4'd1; b_addr = 4'd2;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_data = 16'($urandom); b_data = 16'($urandom);
            @(negedge clk);
            checks++;
            if ({a_ready, b_ready} !== {expReadyA(), expReadyB()} || (a_ready ^ b_ready) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL alt_grant: got %b%b required %b%b", a_ready, b_ready, expReadyA(), expReadyB());
            end
            cur = a_ready ? 0 : 1;
            checks++;
            if (prev >= 0 && cur == prev) begin
                errors++;
                $display("[TB] FAIL alt_starve: source %0d granted twice in a row, required alternation", cur);
            end
            prev = cur;
            checks++;
            if ({wr_en, wr_addr, wr_data} !== expWrPort()) begin
                errors++;
                $display("[TB] FAIL alt_write: got %h required %h", {wr_en, wr_addr, wr_data}, expWrPort());
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int writes = 0;
        for (int c = 0; c < 8; c++) begin
            a_valid = (c < 5); b_valid = 1'b0;
            a_addr = 4'(8 + c); a_data = 16'($urandom);
            @(negedge clk);
            checks++;
            if (a_ready !== expReadyA() || pending > DEPTH || pending !== (PW+1)'(mq.size())) begin
                errors++;
                $display("[TB] FAIL b2b_flow: got ready=%b pend=%0d required ready=%b pend=%0d",
                         a_ready, pending, expReadyA(), mq.size());
            end
            checks++;
            if ({wr_en, wr_addr, wr_data} !== expWrPort()) begin
                errors++;
                $display("[TB] FAIL b2b_write: got %h required %h", {wr_en, wr_addr, wr_data}, expWrPort());
            end
            if (wr_en === 1'b1) writes++;
            tick();
        end
        checks++;
        if (writes != 5) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d writes required 5", writes);
        end
    endtask

    task automatic test_hazard();
        a_valid = 1'b1; b_valid = 1'b0; a_addr = 4'd5; a_data = 16'h5A5A; q_addr = 4'd5;
        @(negedge clk);
        checks++;
        if (q_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_before: got %b required 0", q_hit);
        end
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (q_hit !== 1'b1 || wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hazard_head: got hit=%b we=%b required 1 1", q_hit, wr_en);
        end
        q_addr = 4'd6;
        #1;
        checks++;
        if (q_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_other: got %b required 0", q_hit);
        end
        q_addr = 4'd5;
        #1;
        tick();
        @(negedge clk);
        checks++;
        if (q_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hazard_after: got %b required 0", q_hit);
        end
        tick();
    endtask

    task automatic test_init();
        int writes = 0;
        int swept  = 0;
        a_valid = 1'b1; b_valid = 1'b0; a_addr = 4'd9; a_data = 16'h0909;
        @(negedge clk);
        tick();
        a_valid = 1'b0; b_valid = 1'b1; b_addr = 4'd10; b_data = 16'h0A0A; init_start = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1 || wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_entry: got b_ready=%b we=%b required 1 1", b_ready, wr_en);
        end
        writes++;
        tick();
        init_start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 40 && mMode != M_RUN; c++) begin
            @(negedge clk);
            checks++;
            if ({a_ready, b_ready, init_busy} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL init_busy_ready: got rdy=%b%b busy=%b required 00 1", a_ready, b_ready, init_busy);
            end
            checks++;
            if (mMode == M_SWEEP) begin
                if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'(swept), 16'h0000}) begin
                    errors++;
                    $display("[TB] FAIL init_sweep: got %h required %h", {wr_en, wr_addr, wr_data}, {1'b1, 4'(swept), 16'h0000});
                end
                swept++;
            end else begin
                if ({wr_en, wr_addr, wr_data} !== expWrPort()) begin
                    errors++;
                    $display("[TB] FAIL init_drain: got %h required %h", {wr_en, wr_addr, wr_data}, expWrPort());
                end
                if (wr_en === 1'b1) writes++;
            end
            tick();
        end
        checks++;
        if (writes != 2 || swept != NUM_REGS || mMode != M_RUN) begin
            errors++;
            $display("[TB] FAIL init_counts: got drained=%0d swept=%0d required 2 16", writes, swept);
        end
        @(negedge clk);
        checks++;
        if (init_busy !== 1'b0 || {a_ready, b_ready} !== {expReadyA(), expReadyB()}) begin
            errors++;
            $display("[TB] FAIL init_exit: got busy=%b rdy=%b%b required 0 %b%b",
                     init_busy, a_ready, b_ready, expReadyA(), expReadyB());
        end
        tick();
        idle(2);
    endtask

    task automatic test_sweep_reset();
        bit reached = 0;
        a_valid = 1'b0; b_valid = 1'b0; init_start = 1'b1;
        @(negedge clk);
        tick();
        init_start = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 30 && !reached; c++) begin
            @(negedge clk);
            if (mMode == M_SWEEP && mSweep == 7) reached = 1;
            else tick();
        end
        checks++;
        if (!reached || wr_addr !== 4'd7) begin
            errors++;
            $display("[TB] FAIL sweep_ctr7: got reached=%0d wa=%h required 1 7", reached, wr_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready, wr_en, wr_addr, wr_data, pending, init_busy, q_hit} !== '0) begin
            errors++;
            $display("[TB] FAIL sweep_reset_now: got rdy=%b%b we=%b wa=%h pend=%0d busy=%b hit=%b required all zero",
                     a_ready, b_ready, wr_en, wr_addr, pending, init_busy, q_hit);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({wr_en, pending, init_busy} !== '0) begin
            errors++;
            $display("[TB] FAIL sweep_reset_hold: got we=%b pend=%0d busy=%b required 0", wr_en, pending, init_busy);
        end
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        #1;
        checks++;
        if (init_busy !== 1'b0 || {a_ready, b_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL sweep_reset_run: got busy=%b rdy=%b%b required 0 10", init_busy, a_ready, b_ready);
        end
        tick();
        idle(2);
        for (int i = 0; i < NUM_REGS; i++) dutRf[i] = expRf[i];
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1)); b_valid = 1'($urandom_range(0, 1));
            a_addr = 4'($urandom); b_addr = 4'($urandom);
            a_data = 16'($urandom); b_data = 16'($urandom);
            q_addr = 4'($urandom); init_start = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            checks++;
            if ({a_ready, b_ready} !== {expReadyA(), expReadyB()}) begin
                errors++;
                $display("[TB] FAIL rnd_ready: cycle %0d got %b%b required %b%b", i, a_ready, b_ready, expReadyA(), expReadyB());
            end
            checks++;
            if ({wr_en, wr_addr, wr_data} !== expWrPort()) begin
                errors++;
                $display("[TB] FAIL rnd_write: cycle %0d got %h required %h", i, {wr_en, wr_addr, wr_data}, expWrPort());
            end
            checks++;
            if (pending !== (PW+1)'(mq.size())) begin
                errors++;
                $display("[TB] FAIL rnd_pending: cycle %0d got %0d required %0d", i, pending, mq.size());
            end
            checks++;
            if ({init_busy, q_hit} !== {mMode != M_RUN, expQHit()}) begin
                errors++;
                $display("[TB] FAIL rnd_status: cycle %0d got busy=%b hit=%b required %b %b",
                         i, init_busy, q_hit, mMode != M_RUN, expQHit());
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; init_start = 1'b0;
        for (int c = 0; c < 40 && (mMode != M_RUN || mq.size() != 0); c++) idle(1);
        idle(1);
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (dutRf[i] !== expRf[i]) begin
                errors++;
                $display("[TB] FAIL regfile[%0d]: got %h required %h", i, dutRf[i], expRf[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            expRf[i] = '0;
            dutRf[i] = '0;
        end
        modelReset();
        test_reset();
        test_single_write();
        test_alternate();
        test_back_to_back();
        test_hazard();
        test_init();
        test_sweep_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
